// File: rtl/prog_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// instruction field widths of the 4-bit processor.
package prog_pkg;

  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 4;
  localparam int WORD_W    = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    BURST,
    RELEASE,
    RUN,
    FAULT
  } state_e;

endpackage

// File: rtl/prog_buffer.sv
// Program word store: DEPTH x DATA_W register file, one synchronous write
// port and one combinational read port.
module prog_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_loader.sv
// Buffers a program from a valid/ready byte stream, writes it to the processor
// in one gap-free burst, then releases the processor. Optional checksum stage
// is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_pkg::*;
#(
  parameter int                   DEPTH       = 16,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_data,
  output logic                       mem_write,
  output logic [OPCODE_W-1:0]        instr,
  output logic [OPERAND_W-1:0]       portin,
  output logic                       PC_reset,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH):0]     word_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  state_e state, state_nx;

  logic [CNT_W-1:0]     burst_idx;
  logic [AW-1:0]        rd_addr;
  logic [WORD_W-1:0]    rd_data;
  logic [WORD_W-1:0]    burst_word;
  logic                 acc;
  logic                 is_halt;
  logic                 at_last;
  logic                 wr_en;

  logic                 mem_write_d, PC_reset_d, in_ready_d;
  logic                 busy_d, done_d, error_d;
  logic [OPCODE_W-1:0]  instr_d;
  logic [OPERAND_W-1:0] portin_d;

  assign acc     = in_valid && in_ready;
  assign is_halt = (in_data[WORD_W-1:OPERAND_W] == HALT_OPCODE);
  assign at_last = (word_count == CNT_W'(DEPTH - 1));
  assign wr_en   = acc && (state == COLLECT) && (is_halt || !at_last);
  assign rd_addr = (state == BURST) ? burst_idx[AW-1:0] : '0;

  // A lone halt word is written and read on the same edge; forward it.
  assign burst_word = (wr_en && (word_count[AW-1:0] == rd_addr)) ? in_data : rd_data;

  prog_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (WORD_W),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (word_count[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;

  always_ff @(posedge clk) begin
    if (state != COLLECT && state_nx == COLLECT) csum <= '0;
    else if (wr_en)                              csum <= csum ^ in_data;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RUN, FAULT: if (start) state_nx = COLLECT;
      COLLECT: begin
        if (acc) begin
          if (is_halt) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_nx = CHECK;
`else
            state_nx = BURST;
`endif
          end else if (at_last) begin
            state_nx = FAULT;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: if (acc) state_nx = (in_data == csum) ? BURST : FAULT;
`endif
      BURST:   if (burst_idx == word_count) state_nx = RELEASE;
      RELEASE: state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port is a flop.
  always_comb begin
    mem_write_d = 1'b0;
    PC_reset_d  = 1'b1;
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    instr_d     = '0;
    portin_d    = '0;
    case (state_nx)
      COLLECT, CHECK: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      BURST: begin
        PC_reset_d          = 1'b0;
        mem_write_d         = 1'b1;
        busy_d              = 1'b1;
        {instr_d, portin_d} = burst_word;
      end
      RELEASE: busy_d = 1'b1;
      RUN: begin
        PC_reset_d = 1'b0;
        done_d     = 1'b1;
      end
      FAULT:   error_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write  <= 1'b0;
      PC_reset   <= 1'b1;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      instr      <= '0;
      portin     <= '0;
      word_count <= '0;
      burst_idx  <= '0;
    end else begin
      mem_write <= mem_write_d;
      PC_reset  <= PC_reset_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      instr     <= instr_d;
      portin    <= portin_d;

      if (state != COLLECT && state_nx == COLLECT) word_count <= '0;
      else if (wr_en)                              word_count <= word_count + CNT_W'(1);

      if (state_nx == BURST) burst_idx <= {1'b0, rd_addr} + CNT_W'(1);
      else                   burst_idx <= '0;
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that fills the 4-bit processor's program memory and then starts it. It receives program words over a valid/ready byte stream and buffers the whole program internally. It then drives the processor's write-side inputs (`mem_write`, `instr`, `portin`, `PC_reset`) with one contiguous burst of writes, so the processor never sees an idle gap while loading. Finally it releases the processor to run.

## Interface
Parameters:
- `DEPTH`, 16: maximum program length in words, including the halt word.
- `HALT_OPCODE`, 4'b0111: opcode that terminates a program.

Ports:
- `clk` in 1: single clock; all logic rises on `posedge clk`.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to begin a new load.
- `in_valid` in 1: a stream word is present.
- `in_ready` out 1: the loader accepts the word.
- `in_data` in 8: program word. `[7:4]` is the opcode and `[3:0]` is the operand.
- `mem_write` out 1: processor program-memory write strobe.
- `instr` out 4: opcode to the processor.
- `portin` out 4: operand to the processor.
- `PC_reset` out 1: processor PC reset/hold.
- `busy` out 1: a load is in progress.
- `done` out 1: the processor is running the loaded program.
- `error` out 1: the load was aborted.
- `word_count` out $clog2(DEPTH)+1: number of words accepted.

## Operation
- A word is accepted when `in_valid && in_ready` is true at a rising edge.
- States and behaviour:
  - IDLE: `PC_reset`=1. On `start`, go to COLLECT and clear `word_count`, `done` and `error`.
  - COLLECT: `in_ready`=1 and `PC_reset`=1. Each accepted word is stored at `buf[word_count]`, then `word_count` increments.
  - Halt word accepted in COLLECT: go to BURST, or to CHECK when the checksum macro is compiled in.
  - Non-halt word accepted while `word_count`==DEPTH-1: go to FAULT. Overflow is fatal and the word is not stored.
  - BURST: `PC_reset`=0 and `mem_write`=1 on every cycle. `instr`/`portin` = `buf[i]` for i = 0..`word_count`-1 on consecutive cycles. After the last word, go to RELEASE.
  - RELEASE: `PC_reset`=1 and `mem_write`=0 for exactly one cycle. This rewinds the processor PC. Then go to RUN.
  - RUN: `PC_reset`=0, `done`=1, `mem_write`=0. `start` re-enters COLLECT and asserts `PC_reset` the next cycle.
  - FAULT: `error`=1, `PC_reset` held at 1, `mem_write`=0. `start` re-enters COLLECT.
- `start` is ignored in COLLECT, CHECK, BURST and RELEASE.
- `busy` is 1 in COLLECT, CHECK, BURST and RELEASE.
- `in_ready` is 0 in every state except COLLECT (and CHECK when compiled in).
- Outside BURST, `instr` and `portin` are 0.

## Timing
- Reset values: `mem_write`=0, `instr`=0, `portin`=0, `PC_reset`=1, `in_ready`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0. State is IDLE.
- Reset asserted mid-operation forces these values immediately, and the buffer contents become don't-care.
- All outputs are registered.
- Halt accepted at edge E without the checksum macro, for an N-word program:
  - `mem_write` is high in cycles E+1 .. E+N.
  - `PC_reset` pulses in cycle E+N+1.
  - `done` rises at E+N+2.
- Any number of idle (`in_valid`=0) cycles during COLLECT has no effect on the processor, because `PC_reset` stays high.
- A 1-word program, the halt word alone, is legal and gives a single write.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - After the halt word, a CHECK state accepts one extra byte.
  - That byte must equal the XOR of all program bytes, including the halt word.
  - Match: go to BURST on the next cycle. Mismatch: go to FAULT, and processor memory is never written.
  - The checksum byte is not counted in `word_count`.
- `PROG_LOADER_CHECKSUM_EN` undefined: there is no CHECK state, and halt leads directly to BURST.

## Structure
- Package `prog_pkg` holds:
  - the state enum (IDLE, COLLECT, CHECK, BURST, RELEASE, RUN, FAULT);
  - the opcode and operand widths (4);
  - the default halt opcode 4'b0111.
- Sub-module `prog_buffer`: a DEPTH x 8 register file with one synchronous write port and one combinational read port, instantiated once.

## Test plan
- Reset with no stimulus -> `PC_reset`=1, `mem_write`=0, `busy`=0, `done`=0.
- `start`, then words 0x63, 0x40, 0x63, 0x41, 0x50, 0x80, 0x51, 0x00, 0x70 with random valid gaps:
  - 9 consecutive `mem_write` cycles with `instr`/`portin` equal to 6/3, 4/0, 6/3, 4/1, 5/0, 8/0, 5/1, 0/0, 7/0;
  - then one `PC_reset` cycle, then `done`=1 and `word_count`=9.
- 16 words with no halt (DEPTH=16) -> `error`=1 after the 16th accepted word, with no `mem_write` and `PC_reset` held at 1.
- Single word 0x70 -> exactly one write (`instr`=7), then RELEASE, then RUN.
- `reset` asserted during BURST -> `mem_write`=0 and `PC_reset`=1 immediately. A following `start` plus a full program loads correctly.
- With `PROG_LOADER_CHECKSUM_EN`, the same 9-word program:
  - checksum 0xF0 -> normal burst;
  - checksum 0xF1 -> `error`=1 and zero writes.
